// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the multiplexed 7-segment display driver.
//   SEG_TABLE   16-entry active-low segment patterns {g,f,e,d,c,b,a};
//               codes 10-15 map to a dash
//   SEG_OFF     all segments dark
//   SEG_DASH    middle bar only
//   AN_OFF      all anodes disabled (active-low)
//   IDX_*       digit slot indices, slot 0 is the rightmost digit
//   seg7_decode helper returning the table entry for a 4-bit code
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [3:0] AN_OFF   = 4'hF;

    localparam logic [1:0] IDX_LS_MIN = 2'd0;
    localparam logic [1:0] IDX_MS_MIN = 2'd1;
    localparam logic [1:0] IDX_LS_HR  = 2'd2;
    localparam logic [1:0] IDX_MS_HR  = 2'd3;

    // Packed so element [0] is the rightmost entry of the concatenation.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg7_decode(input logic [3:0] value);
        return SEG_TABLE[value];
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// ---------------------------------------------------------------------------
// bcd_to_seg7
// Purely combinational BCD to active-low 7-segment decoder.
//   bcd  in  4  digit code, 0-9 valid, 10-15 shown as a dash
//   seg  out 7  {g,f,e,d,c,b,a}, active-low
// ---------------------------------------------------------------------------
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    assign seg = seg7_decode(bcd);

endmodule

// File: rtl/seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// seg7_scan_driver
// Drives a common-anode 4-digit multiplexed display showing HH:MM plus a
// blinking colon. A prescaler paces the digit scan and the four digits are
// captured once per frame so one scan never mixes two different times.
//   clk          in   1  system clock
//   rst          in   1  synchronous active-high reset
//   enable       in   1  0 darkens the display, scan keeps running
//   blank_lz     in   1  blank the tens-of-hours digit when it is zero
//   sec_pulse    in   1  one-cycle pulse per second, toggles the colon
//   time_ms_hr   in   4  BCD tens of hours
//   time_ls_hr   in   4  BCD units of hours
//   time_ms_min  in   4  BCD tens of minutes
//   time_ls_min  in   4  BCD units of minutes
//   an           out  4  anode enables, active-low, an[0] = units of minutes
//   seg          out  7  {g,f,e,d,c,b,a}, active-low
//   dp           out  1  colon, active-low, only in the units-of-hours slot
// ---------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       blank_lz,
    input  logic       sec_pulse,
    input  logic [3:0] time_ms_hr,
    input  logic [3:0] time_ls_hr,
    input  logic [3:0] time_ms_min,
    input  logic [3:0] time_ls_min,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0][3:0]  snap_q, snap_d;
    logic             colon_q, colon_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic [3:0]       cur_digit;
    logic [6:0]       dec_seg;

    assign cur_digit = snap_q[idx_q];

    bcd_to_seg7 u_decode (
        .bcd (cur_digit),
        .seg (dec_seg)
    );

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    // Capture only at the very start of a frame so a scan never shows a torn time.
    always_comb begin
        snap_d = snap_q;
        if (idx_q == IDX_LS_MIN && cnt_q == '0) begin
            snap_d[IDX_LS_MIN] = time_ls_min;
            snap_d[IDX_MS_MIN] = time_ms_min;
            snap_d[IDX_LS_HR]  = time_ls_hr;
            snap_d[IDX_MS_HR]  = time_ms_hr;
        end
    end

    always_comb begin
        colon_d = sec_pulse ? ~colon_q : colon_q;
    end

    // The dead cycles at the start of each slot stop ghosting while anodes switch.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (enable && cnt_q >= CNT_BLANK) begin
            if (!(blank_lz && idx_q == IDX_MS_HR && snap_q[IDX_MS_HR] == 4'd0)) begin
                an_d  = ~(4'b0001 << idx_q);
                seg_d = dec_seg;
            end
            dp_d = ~(idx_q == IDX_LS_HR && colon_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            colon_q <= 1'b1;
            an_q    <= AN_OFF;
            seg_q   <= SEG_OFF;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            colon_q <= colon_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_driver
// Self-checking bench for seg7_scan_driver with DIGIT_CYCLES=8, BLANK_CYCLES=2.
// A frame-level model (elapsed cycles since reset -> slot/phase/frame) predicts
// every output each cycle; literal expectations pin the model at key points.
// ---------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int DC = 8;
    localparam int BC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       blank_lz = 1'b0;
    logic       sec_pulse = 1'b0;
    logic [3:0] time_ms_hr = 4'd0;
    logic [3:0] time_ls_hr = 4'd0;
    logic [3:0] time_ms_min = 4'd0;
    logic [3:0] time_ls_min = 4'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    seg7_scan_driver #(
        .DIGIT_CYCLES (DC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .blank_lz    (blank_lz),
        .sec_pulse   (sec_pulse),
        .time_ms_hr  (time_ms_hr),
        .time_ls_hr  (time_ls_hr),
        .time_ms_min (time_ms_min),
        .time_ls_min (time_ls_min),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    always #5 clk = ~clk;

    int check_count = 0;
    int pass_count  = 0;
    int k = 0;

    // Frame-level reference model state
    int         m_t;
    int         m_snap [4];
    logic       m_colon;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    logic       model_valid = 1'b0;
    logic [3:0] an_pattern [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    function automatic logic [6:0] ref_decode(input int v);
        case (v)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    always @(posedge clk) begin
        int slot;
        int phase;
        if (rst) begin
            m_t = 0;
            for (int i = 0; i < 4; i++) m_snap[i] = 0;
            m_colon = 1'b1;
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
        end else begin
            slot  = (m_t / DC) % 4;
            phase = m_t % DC;
            exp_an  = 4'hF;
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
            if (enable && phase >= BC) begin
                if (!(blank_lz && slot == 3 && m_snap[3] == 0)) begin
                    exp_an  = an_pattern[slot];
                    exp_seg = ref_decode(m_snap[slot]);
                end
                exp_dp = !(slot == 2 && m_colon);
            end
            if (m_t % (4 * DC) == 0) begin
                m_snap[0] = int'(time_ls_min);
                m_snap[1] = int'(time_ms_min);
                m_snap[2] = int'(time_ls_hr);
                m_snap[3] = int'(time_ms_hr);
            end
            if (sec_pulse) m_colon = ~m_colon;
            m_t++;
        end
        model_valid = 1'b1;
    end

    task automatic checkField(input string name, input logic [7:0] act, input logic [7:0] want);
        check_count++;
        if (act === want) pass_count++;
        else $display("[TB] FAIL %s k=%0d: actual %h, required %h", name, k, act, want);
    endtask

    // Compare process: DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (model_valid) begin
            checkField("model_an",  {4'h0, an},  {4'h0, exp_an});
            checkField("model_seg", {1'b0, seg}, {1'b0, exp_seg});
            checkField("model_dp",  {7'h0, dp},  {7'h0, exp_dp});
        end
    end

    task automatic checkOutput(input string name, input logic [3:0] w_an,
                               input logic [6:0] w_seg, input logic w_dp);
        checkField({name, "_an"},  {4'h0, an},  {4'h0, w_an});
        checkField({name, "_seg"}, {1'b0, seg}, {1'b0, w_seg});
        checkField({name, "_dp"},  {7'h0, dp},  {7'h0, w_dp});
    endtask

    task automatic applyStimulus(input logic [3:0] msh, input logic [3:0] lsh,
                                 input logic [3:0] msm, input logic [3:0] lsm,
                                 input logic en, input logic blz);
        time_ms_hr  = msh;
        time_ls_hr  = lsh;
        time_ms_min = msm;
        time_ls_min = lsm;
        enable      = en;
        blank_lz    = blz;
    endtask

    task automatic stepTo(input int target);
        while (k < target) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic doReset(input int cycles);
        rst = 1'b1;
        repeat (cycles) begin
            @(negedge clk);
            checkOutput("reset", 4'hF, 7'h7F, 1'b1);
        end
        rst = 1'b0;
        k = 0;
    endtask

    initial begin
        // Reset hold, then 12:34
        applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b0);
        doReset(3);
        stepTo(2);  checkOutput("first_dark", 4'hF, 7'h7F, 1'b1);
        stepTo(3);  checkOutput("first_lit",  4'hE, 7'h19, 1'b1);
        stepTo(9);  checkOutput("gap",        4'hF, 7'h7F, 1'b1);
        stepTo(11); checkOutput("slot1",      4'hD, 7'h30, 1'b1);
        // 23:59 arrives mid-frame and must stay hidden until the next frame
        stepTo(12); applyStimulus(4'd2, 4'd3, 4'd5, 4'd9, 1'b1, 1'b0);
        stepTo(19); checkOutput("slot2",      4'hB, 7'h24, 1'b0);
        stepTo(27); checkOutput("slot3",      4'h7, 7'h79, 1'b1);
        stepTo(35); checkOutput("f2_slot0",   4'hE, 7'h10, 1'b1);
        stepTo(43); checkOutput("f2_slot1",   4'hD, 7'h12, 1'b1);
        stepTo(51); checkOutput("f2_slot2",   4'hB, 7'h30, 1'b0);
        stepTo(59); checkOutput("f2_slot3",   4'h7, 7'h24, 1'b1);

        // 09:15 with leading-zero blanking
        applyStimulus(4'd0, 4'd9, 4'd1, 4'd5, 1'b1, 1'b1);
        doReset(1);
        stepTo(3);  checkOutput("lz_slot0",   4'hE, 7'h12, 1'b1);
        stepTo(27); checkOutput("lz_blank",   4'hF, 7'h7F, 1'b1);
        stepTo(33); blank_lz = 1'b0;
        stepTo(59); checkOutput("lz_off",     4'h7, 7'h40, 1'b1);
        stepTo(60); time_ls_min = 4'hC;
        stepTo(67); checkOutput("dash",       4'hE, 7'h3F, 1'b1);

        // Colon toggling, enable, mid-slot reset
        applyStimulus(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b0);
        doReset(1);
        stepTo(19); checkOutput("colon_on",   4'hB, 7'h24, 1'b0);
        stepTo(25); sec_pulse = 1'b1;
        stepTo(26); sec_pulse = 1'b0;
        stepTo(51); checkOutput("colon_off",  4'hB, 7'h24, 1'b1);
        stepTo(60); sec_pulse = 1'b1;
        stepTo(61); sec_pulse = 1'b0;
        stepTo(83); checkOutput("colon_back", 4'hB, 7'h24, 1'b0);
        stepTo(84); enable = 1'b0;
        stepTo(85); checkOutput("disabled",   4'hF, 7'h7F, 1'b1);
        enable = 1'b1;
        stepTo(86); checkOutput("reenabled",  4'hB, 7'h24, 1'b0);
        doReset(1);

        // Randomized traffic, checked by the model every cycle
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            k++;
            if ($urandom_range(0, 7) == 0) begin
                time_ms_hr  = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                time_ls_hr  = 4'($urandom_range(0, 15));
                time_ms_min = 4'($urandom_range(0, 15));
                time_ls_min = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            enable    = ($urandom_range(0, 9) != 0);
            sec_pulse = ($urandom_range(0, 11) == 0);
            rst       = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
